mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Multi-cycle arbiter that shares the single-ported data RAM between the CPU's instruction-fetch path and its load/store path. It sequences the RAM's MOV/MOC handshake and latches the address, write data and read data for each access. It also drives a stall to the program counter and pipeline control until the pending access completes. It sits between `mips_cpu` (fetch/load-store request ports) and `RAM`.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 15, cycles to wait for MOC before abort (used only with `MEM_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request; held high with `if_addr` stable until `if_done`
- `if_addr`  in  AW  fetch address
- `if_rdata`  out  DW  fetched word; holds its value between fetches
- `if_done`  out  1  one-cycle completion pulse for fetch
- `d_req`  in  1  data request; held with `d_rw`, `d_addr` and `d_wdata` stable until `d_done`
- `d_rw`  in  1  1 = read, 0 = write
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load data; holds its value between loads
- `d_done`  out  1  one-cycle completion pulse for data
- `stall`  out  1  high while any request is asserted and its done has not yet pulsed
- `ram_enable`, `ram_mov`, `ram_rw`  out  1  RAM enable, operation valid, read/write (1 = read)
- `ram_addr`  out  AW, `ram_wdata`  out  DW  RAM address and write data
- `ram_rdata`  in  DW, `ram_moc`  in  1  RAM read data and operation complete
- `bus_err`  out  1  one-cycle abort pulse (timeout build only; otherwise tied to 0)

## Operation
- State machine with three states:
  - IDLE → ACCESS on a grant.
  - ACCESS → RELEASE when `ram_moc` is sampled 1, or on timeout.
  - RELEASE → IDLE when `ram_moc` is sampled 0.
- Grant in IDLE:
  - Only one request present: grant it.
  - Both present: round-robin on `last_owner`; the port not served last wins.
  - `last_owner` resets to fetch, so the first tie goes to data.
- Grant registers `owner` and the RAM outputs:
  - `ram_enable` = 1, `ram_mov` = 1.
  - `ram_addr` = the owner's address.
  - `ram_rw` = `d_rw` for data, 1 for fetch.
  - `ram_wdata` = `d_wdata` for data, 0 for fetch.
- ACCESS: outputs are held. When `ram_moc` is sampled 1:
  - A read captures `ram_rdata` into the owner's rdata register. A write leaves `d_rdata` unchanged.
  - The owner's done is pulsed.
  - `ram_mov` and `ram_enable` drop to 0 and `last_owner` is updated.
- RELEASE: no new grant is made until `ram_moc` has returned to 0, then the FSM returns to IDLE.
- A request still high in the cycle after its done is treated as a new request.
- A requester that drops its request before done is ignored: the access completes and done still pulses.
- `stall` = (`if_req` & ~`if_done`) | (`d_req` & ~`d_done`), combinational.
- Reset at any point, including mid-access:
  - State → IDLE, `last_owner` → fetch.
  - All outputs → 0, including both rdata registers, the dones, `bus_err` and the RAM outputs.
  - The in-flight access is abandoned.

## Timing
- All outputs except `stall` are registered.
- Request sampled at edge k in IDLE: RAM outputs valid after edge k.
- `ram_moc` first sampled high at edge m: rdata and done valid in cycle m+1 for exactly one cycle; `ram_mov` low from m+1.
- Minimum request-to-done latency is 2 cycles: `ram_moc` already high at the first ACCESS edge.
- Minimum spacing between grants: done cycle + 1 RELEASE cycle (MOC low) + 1 IDLE cycle, i.e. a grant at least 3 cycles after the previous grant edge.
- `if_rdata` and `d_rdata` are stable from the done cycle until the next completed read on the same port.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each cycle in ACCESS.
  - At `TIMEOUT` cycles without `ram_moc`, the access aborts: `bus_err` and the owner's done pulse together for one cycle.
  - rdata is unchanged, `ram_mov` drops, and the FSM goes to RELEASE.
- Not defined: ACCESS waits indefinitely, no counter is built, and `bus_err` is constant 0.

## Test plan
- Reset with both requests low: all outputs 0; assert `reset` mid-ACCESS, and `ram_mov` goes low asynchronously and the FSM is in IDLE after release.
- Fetch only, `if_addr` = 0x0000_0040, RAM returns 0x2008_0005 with MOC after 3 cycles: `ram_rw` = 1, `ram_addr` = 0x40, `if_rdata` = 0x2008_0005, `if_done` high exactly 1 cycle, `stall` low after.
- Data write, `d_addr` = 0x100, `d_wdata` = 0xCAFE_F00D: `ram_rw` = 0, `ram_wdata` = 0xCAFE_F00D, `d_done` pulses, `d_rdata` stays 0.
- Both requests asserted at the same edge after reset: data is served first, then fetch; with both held continuously, grants alternate D, I, D, I.
- MOC held high for 4 cycles after completion: no new grant until MOC is sampled 0; the next grant is 1 cycle later.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT` = 15, MOC never asserted: after 15 ACCESS cycles `bus_err` and `d_done` pulse together and rdata is unchanged; without the macro, done never pulses and `stall` stays high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data RAM between instruction fetch and load/store, round-robin on ties.
// Optional MOC watchdog (bus_err abort) is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          stall,
  output logic          ram_enable,
  output logic          ram_mov,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_moc,
  output logic          bus_err,
  output logic [1:0]    dbg_state
);
  // Requesters: req is valid, done is the one-cycle ready; fields stay stable while req is high
  // until done. RAM side: mov is held until moc is sampled high, and no new mov until moc is low.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RELEASE = 2'd2} state_t;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          ram_enable_q, ram_enable_d;
  logic          ram_mov_q, ram_mov_d;
  logic          ram_rw_q, ram_rw_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          grant_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    ram_enable_d = ram_enable_q;
    ram_mov_d    = ram_mov_q;
    ram_rw_d     = ram_rw_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = 1'b0;
`endif
    // Data wins when alone, or on a tie when fetch was served last.
    grant_data = d_req & (~if_req | (last_owner_q == OWN_FETCH));

    case (state_q)
      S_IDLE: begin
        if (if_req | d_req) begin
          state_d      = S_ACCESS;
          owner_d      = grant_data ? OWN_DATA : OWN_FETCH;
          ram_enable_d = 1'b1;
          ram_mov_d    = 1'b1;
          ram_addr_d   = grant_data ? d_addr : if_addr;
          ram_rw_d     = grant_data ? d_rw : 1'b1;
          ram_wdata_d  = grant_data ? d_wdata : '0;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      S_ACCESS: begin
        if (ram_moc) begin
          if (ram_rw_q) begin
            if (owner_q == OWN_DATA) d_rdata_d = ram_rdata;
            else                     if_rdata_d = ram_rdata;
          end
          if_done_d    = (owner_q == OWN_FETCH);
          d_done_d     = (owner_q == OWN_DATA);
          ram_mov_d    = 1'b0;
          ram_enable_d = 1'b0;
          last_owner_d = owner_q;
          state_d      = S_RELEASE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          if_done_d    = (owner_q == OWN_FETCH);
          d_done_d     = (owner_q == OWN_DATA);
          bus_err_d    = 1'b1;
          ram_mov_d    = 1'b0;
          ram_enable_d = 1'b0;
          last_owner_d = owner_q;
          state_d      = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (!ram_moc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      ram_enable_q <= 1'b0;
      ram_mov_q    <= 1'b0;
      ram_rw_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      ram_enable_q <= ram_enable_d;
      ram_mov_q    <= ram_mov_d;
      ram_rw_q     <= ram_rw_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign if_done    = if_done_q;
  assign d_done     = d_done_q;
  assign ram_enable = ram_enable_q;
  assign ram_mov    = ram_mov_q;
  assign ram_rw     = ram_rw_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign dbg_state  = state_q;
  assign stall      = (if_req & ~if_done_q) | (d_req & ~d_done_q);

`ifdef MEM_ARB_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  // No watchdog in this build; the expression is constant 0 for any legal TIMEOUT.
  assign bus_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized two-port traffic against
// a transaction-level memory/arbitration model and a behavioural RAM responder.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_rw;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          if_done, d_done, stall;
  logic          ram_enable, ram_mov, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_moc;
  logic          bus_err;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
    .ram_enable(ram_enable), .ram_mov(ram_mov), .ram_rw(ram_rw),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_moc(ram_moc),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ram_mem [64];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_if_q [$];
  logic [DW-1:0] exp_d_q [$];
  int            grant_log [$];

  // behavioural RAM responder
  int  resp_delay = 0;
  int  resp_hold  = 0;
  bit  resp_rand  = 1'b0;
  bit  resp_never = 1'b0;
  typedef enum {R_IDLE, R_WAIT, R_HIGH, R_HOLD, R_NEVER} rstate_t;
  rstate_t rs = R_IDLE;
  int      r_left;

  task automatic ram_fire();
    int idx = int'(ram_addr[7:2]);
    if (ram_rw) ram_rdata = ram_mem[idx];
    else begin
      ram_mem[idx] = ram_wdata;
      ram_rdata = $urandom;
    end
    ram_moc = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      rs = R_IDLE;
      ram_moc = 1'b0;
    end else begin
      case (rs)
        R_IDLE: if (ram_mov) begin
          if (resp_never) rs = R_NEVER;
          else begin
            r_left = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
            if (r_left == 0) begin ram_fire(); rs = R_HIGH; end
            else rs = R_WAIT;
          end
        end
        R_WAIT: begin
          r_left--;
          if (r_left == 0) begin ram_fire(); rs = R_HIGH; end
        end
        R_HIGH: if (!ram_mov) begin
          r_left = resp_rand ? int'($urandom_range(0, 2)) : resp_hold;
          if (r_left == 0) begin ram_moc = 1'b0; rs = R_IDLE; end
          else rs = R_HOLD;
        end
        R_HOLD: begin
          r_left--;
          if (r_left == 0) begin ram_moc = 1'b0; rs = R_IDLE; end
        end
        R_NEVER: if (!ram_mov) rs = R_IDLE;
        default: rs = R_IDLE;
      endcase
    end
  end

  // arbitration model + stall check, sampled around each rising edge
  logic          s_if, s_d, s_rw;
  logic [AW-1:0] s_ia, s_da;
  logic [DW-1:0] s_wd;
  bit            mov_prev = 1'b0;
  bit            last_w = 1'b0;
  bit            exp_w;
  int            obs_w;

  always @(posedge clk) begin
    s_if = if_req; s_d = d_req; s_rw = d_rw; s_ia = if_addr; s_da = d_addr; s_wd = d_wdata;
    #1;
    if (reset) begin
      last_w = 1'b0;
      mov_prev = 1'b0;
    end else begin
      n_cmp++;
      if (stall !== ((if_req && !if_done) || (d_req && !d_done))) begin
        n_err++;
        $display("FAIL stall @%0t: got %b expected %b", $time, stall,
                 (if_req && !if_done) || (d_req && !d_done));
      end
      if (ram_mov && !mov_prev) begin
        obs_w = (ram_addr == s_da && ram_addr != s_ia) ? 1 : ((ram_addr == s_ia) ? 0 : 2);
        grant_log.push_back(obs_w);
        n_cmp++;
        if (!s_if && !s_d) begin
          n_err++;
          $display("FAIL grant_spurious @%0t: got grant expected none", $time);
        end else begin
          exp_w = (s_if && s_d) ? !last_w : s_d;
          if (exp_w) begin
            if ({ram_enable, ram_rw, ram_addr, ram_wdata} !== {1'b1, s_rw, s_da, s_wd}) begin
              n_err++;
              $display("FAIL grant_data @%0t: got rw=%b addr=%h wd=%h expected rw=%b addr=%h wd=%h",
                       $time, ram_rw, ram_addr, ram_wdata, s_rw, s_da, s_wd);
            end
          end else begin
            if ({ram_enable, ram_rw, ram_addr, ram_wdata} !== {1'b1, 1'b1, s_ia, {DW{1'b0}}}) begin
              n_err++;
              $display("FAIL grant_fetch @%0t: got rw=%b addr=%h wd=%h expected rw=1 addr=%h wd=0",
                       $time, ram_rw, ram_addr, ram_wdata, s_ia);
            end
          end
          last_w = exp_w;
        end
      end
      mov_prev = ram_mov;
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    resp_never = 1'b0; resp_rand = 1'b0; resp_delay = 0; resp_hold = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({if_rdata, d_rdata} !== '0) begin
      n_err++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, d_rdata);
    end
    n_cmp++;
    if ({if_done, d_done, stall, bus_err, ram_enable, ram_mov, ram_rw} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {if_done, d_done, stall, bus_err, ram_enable, ram_mov, ram_rw});
    end
    n_cmp++;
    if ({ram_addr, ram_wdata} !== '0) begin
      n_err++; $display("FAIL reset_ram: got %h/%h expected 0/0", ram_addr, ram_wdata);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_fetch();
    int n;
    do_reset();
    resp_delay = 3;
    @(negedge clk);
    ram_mem[16] = 32'h2008_0005;
    if_addr = 32'h0000_0040; if_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_mov && n < 20);
    n_cmp++;
    if ({ram_mov, ram_rw, ram_addr} !== {1'b1, 1'b1, 32'h40}) begin
      n_err++; $display("FAIL fetch_ram: got mov=%b rw=%b addr=%h expected 1 1 40", ram_mov, ram_rw, ram_addr);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 40);
    n_cmp++;
    if (n !== 4) begin n_err++; $display("FAIL fetch_latency: got %0d expected 4", n); end
    n_cmp++;
    if (if_rdata !== 32'h2008_0005) begin
      n_err++; $display("FAIL fetch_rdata: got %h expected 20080005", if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_done, stall, ram_mov} !== 3'b000 || if_rdata !== 32'h2008_0005) begin
      n_err++; $display("FAIL fetch_after: got done=%b stall=%b mov=%b rdata=%h expected 0 0 0 20080005",
                        if_done, stall, ram_mov, if_rdata);
    end
  endtask

  task automatic test_write();
    int n;
    do_reset();
    resp_delay = 1;
    @(negedge clk);
    d_rw = 1'b0; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_mov && n < 20);
    n_cmp++;
    if ({ram_rw, ram_addr, ram_wdata} !== {1'b0, 32'h100, 32'hCAFE_F00D}) begin
      n_err++; $display("FAIL write_ram: got rw=%b addr=%h wd=%h expected 0 100 cafef00d", ram_rw, ram_addr, ram_wdata);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!d_done && n < 40);
    n_cmp++;
    if (d_done !== 1'b1 || d_rdata !== 32'h0 || ram_mem[0] !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL write_done: got done=%b rdata=%h mem=%h expected 1 0 cafef00d", d_done, d_rdata, ram_mem[0]);
    end
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (d_done !== 1'b0 || d_rdata !== 32'h0) begin
      n_err++; $display("FAIL write_pulse: got done=%b rdata=%h expected 0 0", d_done, d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int n, got, exp;
    do_reset();
    grant_log.delete();
    @(negedge clk);
    if_addr = 32'h40; d_addr = 32'h80; d_rw = 1'b1; d_wdata = 32'h1234_5678;
    if_req = 1'b1; d_req = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 1 : 0;
      got = (i < grant_log.size()) ? grant_log[i] : -1;
      n_cmp++;
      if (got != exp) begin
        n_err++; $display("FAIL tie_order[%0d]: got owner %0d expected %0d (1=data)", i, got, exp);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_moc_hold();
    int n;
    do_reset();
    resp_delay = 0; resp_hold = 4;
    @(negedge clk);
    if_addr = 32'h48; if_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 20);
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_mov && n < 20);
    n_cmp++;
    if (n !== 6) begin n_err++; $display("FAIL moc_hold_gap: got %0d expected 6", n); end
    resp_hold = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 20);
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_mov && n < 20);
    n_cmp++;
    if (n !== 2) begin n_err++; $display("FAIL min_spacing: got %0d expected 2", n); end
    if_req = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    resp_never = 1'b1;
    @(negedge clk);
    d_rw = 1'b1; d_addr = 32'h0C; d_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_mov && n < 20);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_done && n < 40);
`ifdef MEM_ARB_TIMEOUT_EN
    n_cmp++;
    if (n !== TMO) begin n_err++; $display("FAIL timeout_latency: got %0d expected %0d", n, TMO); end
    n_cmp++;
    if ({d_done, bus_err, ram_mov} !== 3'b110 || d_rdata !== 32'h0) begin
      n_err++; $display("FAIL timeout_abort: got done=%b err=%b mov=%b rdata=%h expected 1 1 0 0",
                        d_done, bus_err, ram_mov, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({d_done, bus_err} !== 2'b00) begin
      n_err++; $display("FAIL timeout_pulse: got done=%b err=%b expected 0 0", d_done, bus_err);
    end
`else
    n_cmp++;
    if (n !== 40 || d_done !== 1'b0) begin
      n_err++; $display("FAIL no_timeout_done: got %0d cycles done=%b expected 40 0", n, d_done);
    end
    n_cmp++;
    if ({stall, bus_err, ram_mov} !== 3'b101) begin
      n_err++; $display("FAIL no_timeout_hold: got stall=%b err=%b mov=%b expected 1 0 1", stall, bus_err, ram_mov);
    end
    d_req = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    resp_delay = 5;
    @(negedge clk);
    if_addr = 32'h44; if_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_mov && n < 20);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({ram_mov, ram_enable} !== 2'b00) begin
      n_err++; $display("FAIL reset_async: got mov=%b en=%b expected 0 0", ram_mov, ram_enable);
    end
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== 2'd0 || {ram_mov, if_done, if_rdata} !== '0) begin
      n_err++; $display("FAIL reset_mid_after: got state=%0d mov=%b done=%b rdata=%h expected 0 0 0 0",
                        dbg_state, ram_mov, if_done, if_rdata);
    end
  endtask

  task automatic fetch_proc(input int cnt);
    int idx, n, gap;
    logic [DW-1:0] e;
    @(negedge clk);
    for (int t = 0; t < cnt; t++) begin
      idx = int'($urandom_range(0, 31));
      if_addr = AW'(idx * 4); if_req = 1'b1;
      exp_if_q.push_back(ref_mem[idx]);
      n = 0;
      do begin @(negedge clk); n++; end while (!if_done && n < 100);
      e = exp_if_q.pop_front();
      n_cmp++;
      if (if_done !== 1'b1 || if_rdata !== e) begin
        n_err++; $display("FAIL rand_fetch[%0d]: got done=%b rdata=%h expected 1 %h", t, if_done, if_rdata, e);
      end
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin if_req = 1'b0; repeat (gap) @(negedge clk); end
    end
    if_req = 1'b0;
  endtask

  task automatic data_proc(input int cnt);
    int idx, n, gap;
    logic rw;
    logic [DW-1:0] wd, e, last_rd;
    last_rd = '0;
    @(negedge clk);
    for (int t = 0; t < cnt; t++) begin
      idx = int'($urandom_range(32, 63));
      rw = 1'($urandom_range(0, 1));
      wd = $urandom;
      d_rw = rw; d_addr = AW'(idx * 4); d_wdata = wd; d_req = 1'b1;
      if (rw) exp_d_q.push_back(ref_mem[idx]);
      n = 0;
      do begin @(negedge clk); n++; end while (!d_done && n < 100);
      if (rw) begin
        e = exp_d_q.pop_front();
        last_rd = e;
      end else begin
        e = last_rd;
        ref_mem[idx] = wd;
      end
      n_cmp++;
      if (d_done !== 1'b1 || bus_err !== 1'b0 || d_rdata !== e) begin
        n_err++; $display("FAIL rand_data[%0d] rw=%b: got done=%b err=%b rdata=%h expected 1 0 %h",
                          t, rw, d_done, bus_err, d_rdata, e);
      end
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin d_req = 1'b0; repeat (gap) @(negedge clk); end
    end
    d_req = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    resp_rand = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    exp_if_q.delete();
    exp_d_q.delete();
    fork
      fetch_proc(25);
      data_proc(25);
    join
    repeat (10) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram_mem[i] !== ref_mem[i]) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL rand_memory: got %0d differing words expected 0", bad); end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_rw = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; ram_rdata = '0; ram_moc = 1'b0;
    for (int i = 0; i < 64; i++) begin ram_mem[i] = '0; ref_mem[i] = '0; end
    test_reset();
    test_fetch();
    test_write();
    test_back_to_back();
    test_moc_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
